// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one combinational adder/subtractor between two requesters.
// Operands are registered onto the adder at grant; results are captured one cycle later.
module addsub_share_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             m0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             m1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res_s,
    output logic             res_cout,
    output logic             res_v,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_m,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_v
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic             ack0_q,       ack0_d;
    logic             ack1_q,       ack1_d;
    logic             done0_q,      done0_d;
    logic             done1_q,      done1_d;
    logic             busy_q,       busy_d;
    logic [WIDTH-1:0] res_s_q,      res_s_d;
    logic             res_cout_q,   res_cout_d;
    logic             res_v_q,      res_v_d;
    logic [WIDTH-1:0] add_a_q,      add_a_d;
    logic [WIDTH-1:0] add_b_q,      add_b_d;
    logic             add_m_q,      add_m_d;
    logic             grant;

    // Next-state, grant selection and output staging
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        res_s_d      = res_s_q;
        res_cout_d   = res_cout_q;
        res_v_d      = res_v_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_m_d      = add_m_q;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes first
                    grant        = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant;
                    owner_d      = grant;
                    state_d      = EXEC;
                    if (grant) begin
                        add_a_d = a1;
                        add_b_d = b1;
                        add_m_d = m1;
                        ack1_d  = 1'b1;
                    end else begin
                        add_a_d = a0;
                        add_b_d = b0;
                        add_m_d = m0;
                        ack0_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                res_s_d    = add_s;
                res_cout_d = add_cout;
                res_v_d    = add_v;
                done0_d    = ~owner_q;
                done1_d    = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
            res_s_q      <= '0;
            res_cout_q   <= 1'b0;
            res_v_q      <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_m_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
            res_s_q      <= res_s_d;
            res_cout_q   <= res_cout_d;
            res_v_q      <= res_v_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_m_q      <= add_m_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;
    assign res_s    = res_s_q;
    assign res_cout = res_cout_q;
    assign res_v    = res_v_q;
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_m    = add_m_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Self-checking bench for addsub_share_arbiter: directed scenarios then randomized
// traffic, checked against an arithmetic reference model of the shared adder service.
module tb_addsub_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, m0, m1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1, done0, done1, busy;
    logic [3:0] res_s, add_a, add_b, add_s;
    logic       res_cout, res_v, add_m, add_cout, add_v;

    int total = 0;
    int bad   = 0;

    // Model state
    logic       pend [2];
    logic [3:0] opa  [2];
    logic [3:0] opb  [2];
    logic       opm  [2];
    int         m_last;
    logic [3:0] m_s;
    logic       m_c, m_v;

    addsub_share_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .m0(m0),
        .req1(req1), .a1(a1), .b1(b1), .m1(m1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res_s(res_s), .res_cout(res_cout), .res_v(res_v), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_m(add_m),
        .add_s(add_s), .add_cout(add_cout), .add_v(add_v)
    );

    // Four-bit ripple adder/subtractor datapath (B inverted and carry-in = M)
    logic [3:0] bx;
    logic [4:0] sum5;
    assign bx       = add_b ^ {4{add_m}};
    assign sum5     = {1'b0, add_a} + {1'b0, bx} + 5'(add_m);
    assign add_s    = sum5[3:0];
    assign add_cout = sum5[4];
    assign add_v    = (add_a[3] == bx[3]) && (sum5[3] != add_a[3]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic m);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        ur = m ? ua - ub : ua + ub;
        sr = m ? sa - sb : sa + sb;
        return {4'(ur & 15), (m ? (ua >= ub) : (ur > 15)), ((sr > 7) || (sr < -8))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input logic ea0, input logic ea1,
                              input logic ed0, input logic ed1, input logic eb);
        chk({tag, "_ctl"}, 32'({ack0, ack1, done0, done1, busy}), 32'({ea0, ea1, ed0, ed1, eb}));
    endtask

    task automatic expect_res(input string tag);
        chk({tag, "_res"}, 32'({res_s, res_cout, res_v}), 32'({m_s, m_c, m_v}));
    endtask

    task automatic drive_reqs();
        req0 = pend[0]; a0 = opa[0]; b0 = opb[0]; m0 = opm[0];
        req1 = pend[1]; a1 = opa[1]; b1 = opb[1]; m1 = opm[1];
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_s     = 4'd0;
        m_c     = 1'b0;
        m_v     = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    // One IDLE cycle: either nothing happens, or a full grant/ack/done sequence
    task automatic step_idle(input string tag);
        int         w;
        logic [5:0] r;
        drive_reqs();
        if (!pend[0] && !pend[1]) begin
            tick();
            expect_ctl({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_res({tag, "_hold"});
            return;
        end
        w = (pend[0] && pend[1]) ? 1 - m_last : (pend[0] ? 0 : 1);
        tick();
        expect_ctl({tag, "_ack"}, 1'(w == 0), 1'(w == 1), 1'b0, 1'b0, 1'b1);
        chk({tag, "_add"}, 32'({add_a, add_b, add_m}), 32'({opa[w], opb[w], opm[w]}));
        r       = ref_op(opa[w], opb[w], opm[w]);
        m_last  = w;
        pend[w] = 1'b0;
        // Winner drops its request and may scribble on its operands during EXEC
        opa[w] = 4'($urandom);
        opb[w] = 4'($urandom);
        opm[w] = 1'($urandom);
        drive_reqs();
        tick();
        m_s = r[5:2];
        m_c = r[1];
        m_v = r[0];
        expect_ctl({tag, "_done"}, 1'b0, 1'b0, 1'(w == 0), 1'(w == 1), 1'b0);
        expect_res({tag, "_done"});
    endtask

    task automatic load(input int r, input logic [3:0] a, input logic [3:0] b, input logic m);
        pend[r] = 1'b1;
        opa[r]  = a;
        opb[r]  = b;
        opm[r]  = m;
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            opa[r] = 4'd0; opb[r] = 4'd0; opm[r] = 1'b0;
        end
        model_reset();
        drive_reqs();
        rst = 1'b1;
        tick();
        tick();
        expect_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_res("reset");
        chk("reset_add", 32'({add_a, add_b, add_m}), 32'd0);
        rst = 1'b0;
        step_idle("idle_after_reset");
        step_idle("idle_again");

        load(0, 4'b0100, 4'b0010, 1'b0);
        step_idle("add_4_2");
        chk("add_4_2_s", 32'(res_s), 32'h6);

        load(1, 4'b0100, 4'b0010, 1'b1);
        step_idle("sub_4_2");
        chk("sub_4_2_scv", 32'({res_s, res_cout, res_v}), 32'({4'b0010, 1'b1, 1'b0}));

        // Tie right after reset goes to requester 0, then the loser
        rst = 1'b1;
        model_reset();
        drive_reqs();
        tick();
        rst = 1'b0;
        load(0, 4'd3, 4'd9, 1'b0);
        load(1, 4'd12, 4'd5, 1'b1);
        step_idle("tie_first");
        chk("tie_first_winner", 32'(m_last), 32'd0);
        step_idle("tie_loser");
        load(0, 4'd1, 4'd1, 1'b1);
        load(1, 4'd15, 4'd15, 1'b0);
        step_idle("tie2_first");
        step_idle("tie2_loser");
        load(0, 4'd8, 4'd8, 1'b0);
        load(1, 4'd8, 4'd1, 1'b1);
        step_idle("tie3_first");
        step_idle("tie3_loser");

        load(0, 4'b0111, 4'b0001, 1'b0);
        step_idle("ovf_7_1");
        chk("ovf_7_1_scv", 32'({res_s, res_cout, res_v}), 32'({4'b1000, 1'b0, 1'b1}));

        // Reset while requester 1's operation is in EXEC
        load(1, 4'd9, 4'd3, 1'b0);
        drive_reqs();
        tick();
        expect_ctl("midrst_ack", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pend[1] = 1'b0;
        drive_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        expect_ctl("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_res("midrst");
        chk("midrst_add", 32'({add_a, add_b, add_m}), 32'd0);
        load(0, 4'd5, 4'd6, 1'b1);
        step_idle("after_midrst");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0))
                    load(r, 4'($urandom), 4'($urandom), 1'($urandom));
            end
            step_idle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
